// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   sched_state_e        : scheduler FSM states
//   TX_BIT_CYCLES        : SYSCLK cycles per UART bit in the TX controller
//   FRAME_BITS           : bit times per transmitted frame (incl. finish)
//   DEFAULT_BUSY_TIMEOUT : default START-to-BUSY limit in cycles
//   GRANT_ID_W           : width of requester indices and the RR pointer
package uart_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sched_state_e;

    localparam int TX_BIT_CYCLES        = 869;
    localparam int FRAME_BITS           = 12;
    localparam int DEFAULT_BUSY_TIMEOUT = 16;
    localparam int GRANT_ID_W           = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational requester picker, round-robin or fixed priority.
//   eligible  : per-requester request vector
//   ptr       : round-robin start index (ignored in fixed mode)
//   prio_mode : 0 = round-robin from ptr, 1 = lowest index wins
//   grant_oh  : one-hot winner (all zero when nothing is eligible)
//   grant_idx : binary winner index
//   grant_any : at least one requester is eligible
module rr_pick
    import uart_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          eligible,
    input  logic [GRANT_ID_W-1:0] ptr,
    input  logic                  prio_mode,
    output logic [N-1:0]          grant_oh,
    output logic [GRANT_ID_W-1:0] grant_idx,
    output logic                  grant_any
);

    logic [GRANT_ID_W-1:0] cand;

    // Walk the candidates in search order; the first eligible one wins.
    // Fixed mode simply starts the walk at index 0 instead of ptr.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            if (prio_mode) begin
                cand = GRANT_ID_W'(k);
            end else begin
                cand = GRANT_ID_W'((int'(ptr) + k) % N);
            end
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
                grant_oh  = N'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Multi-requester scheduler in front of the shared UART TX controller.
// Arbitrates between NUM_REQ byte sources, launches one frame at a time
// and follows the controller's busy flag until the frame completes.
//   sysclk, rst   : clock and asynchronous active-high reset
//   req_valid     : per-requester byte valid
//   req_data      : per-requester byte, requester i at [8i+7:8i]
//   req_ready     : one-hot accept strobe (combinational, idle only)
//   req_mask      : per-requester enable
//   prio_mode     : 0 = round-robin, 1 = fixed priority (index 0 first)
//   tx_start      : one-cycle start pulse to the TX controller
//   tx_data       : byte to the TX controller, held until the next grant
//   tx_busy       : busy flag from the TX controller
//   grant_id      : index of the last granted requester
//   sched_busy    : high whenever the scheduler is not idle
//   err_timeout   : sticky, busy never rose after a start
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [8*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_mask,
    input  logic                  prio_mode,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy,
    output logic [GRANT_ID_W-1:0] grant_id,
    output logic                  sched_busy,
    output logic                  err_timeout
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    sched_state_e          state_q, state_d;
    logic [GRANT_ID_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [GRANT_ID_W-1:0] grant_id_q, grant_id_d;
    logic                  tx_start_q, tx_start_d;
    logic                  sched_busy_q, sched_busy_d;
    logic                  err_q, err_d;

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    pick_oh;
    logic [GRANT_ID_W-1:0] pick_idx;
    logic                  pick_any;
    logic                  grant;
    logic                  timeout_hit;

    assign eligible = req_valid & req_mask;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .prio_mode (prio_mode),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .grant_any (pick_any)
    );

    // The busy gate also covers a controller still finishing a frame
    // after our own reset.
    assign grant = (state_q == ST_IDLE) && !tx_busy && pick_any;

    // State and datapath registers.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            tx_data_q    <= 8'h00;
            grant_id_q   <= '0;
            tx_start_q   <= 1'b0;
            sched_busy_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            tx_data_q    <= tx_data_d;
            grant_id_q   <= grant_id_d;
            tx_start_q   <= tx_start_d;
            sched_busy_q <= sched_busy_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic. Busy rising wins over the timeout in the same cycle.
    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (int'(cnt_q) + 1 >= BUSY_TIMEOUT) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values. The counter holds the number of
    // cycles since the launch cycle while waiting for busy.
    always_comb begin
        req_ready    = grant ? pick_oh : '0;
        tx_start_d   = grant;
        tx_data_d    = tx_data_q;
        grant_id_d   = grant_id_q;
        ptr_d        = ptr_q;
        cnt_d        = '0;
        err_d        = err_q | timeout_hit;
        sched_busy_d = (state_d != ST_IDLE);
        if (grant) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pick_oh[i]) tx_data_d = req_data[8*i +: 8];
            end
            grant_id_d = pick_idx;
            ptr_d      = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + GRANT_ID_W'(1);
        end
        if (state_q == ST_LAUNCH) begin
            cnt_d = CNT_W'(1);
        end else if (state_q == ST_WAIT_BUSY && !tx_busy && !timeout_hit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign sched_busy  = sched_busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: requester FIFOs, a TX controller
// model and a cycle reference model of the scheduler's documented rules.
module tb_uart_tx_sched;
    import uart_sched_pkg::*;

    localparam int NUM_REQ      = 4;
    localparam int BUSY_TIMEOUT = 16;
    localparam int FULL_FRAME   = TX_BIT_CYCLES * FRAME_BITS;
    localparam int FIFO_DEPTH   = 64;

    logic                  sysclk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [8*NUM_REQ-1:0]  req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_mask;
    logic                  prio_mode;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_busy;
    logic [GRANT_ID_W-1:0] grant_id;
    logic                  sched_busy;
    logic                  err_timeout;

    uart_tx_sched #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .req_mask    (req_mask),
        .prio_mode   (prio_mode),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .sched_busy  (sched_busy),
        .err_timeout (err_timeout)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int err_count   = 0;
    int check_count = 0;
    int cyc         = 0;

    // Requester byte FIFOs
    logic [7:0] fifo_mem [NUM_REQ][FIFO_DEPTH];
    int fifo_head [NUM_REQ];
    int fifo_tail [NUM_REQ];
    bit hold_low  [NUM_REQ];

    // Pending input values, applied at the next falling edge
    logic nxt_rst;
    logic [NUM_REQ-1:0] nxt_mask;
    logic nxt_prio;

    // TX controller model
    int rise_cnt   = 0;
    int busy_left  = 0;
    int frame_len  = 20;
    bit no_busy    = 0;
    bit force_busy = 0;

    // Reference model: 0 idle, 1 launch, 2 waiting for busy, 3 waiting for done
    int m_phase = 0;
    int m_ptr   = 0;
    int m_launch_cyc = 0;
    int m_gid   = 0;
    logic [7:0] m_data = 8'h00;
    bit m_start = 0;
    bit m_err   = 0;

    int grant_log [$];
    int start_count  = 0;
    int ready_count  = 0;
    int ready3_count = 0;
    int last_start_cyc = 0;
    int err_rise_cyc   = -1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic int fifoCount(input int i);
        return fifo_tail[i] - fifo_head[i];
    endfunction

    function automatic int pendingTotal();
        int s = 0;
        for (int i = 0; i < NUM_REQ; i++) s += fifoCount(i);
        return s;
    endfunction

    function automatic int logAt(input int k);
        return (k < grant_log.size()) ? grant_log[k] : -1;
    endfunction

    // First eligible index at or after the start point, wrapping around;
    // fixed priority is the same search starting from index 0.
    function automatic int refPick(input logic [NUM_REQ-1:0] e, input int ptr, input logic prio);
        int first;
        int idx;
        first = prio ? 0 : ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (first + k) % NUM_REQ;
            if (e[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic pushByte(input int i, input logic [7:0] b);
        fifo_mem[i][fifo_tail[i] % FIFO_DEPTH] = b;
        fifo_tail[i]++;
    endtask

    task automatic withdrawReq(input int i);
        if (fifoCount(i) > 0) begin
            fifo_head[i]++;
            hold_low[i] = 1'b1;
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then check the
    // DUT against the model and advance the model to the next cycle.
    task automatic applyStimulus();
        logic [NUM_REQ-1:0] elig;
        logic [NUM_REQ-1:0] exp_ready;
        int win;
        @(negedge sysclk);
        cyc++;
        rst       = nxt_rst;
        req_mask  = nxt_mask;
        prio_mode = nxt_prio;
        if (force_busy) begin
            tx_busy   = 1'b1;
            busy_left = 0;
            rise_cnt  = 0;
        end else if (rise_cnt > 0) begin
            rise_cnt--;
            if (rise_cnt == 0) begin
                tx_busy   = 1'b1;
                busy_left = frame_len;
            end
        end else if (tx_busy) begin
            if (busy_left <= 1) tx_busy = 1'b0;
            else busy_left--;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = (fifoCount(i) > 0) && !hold_low[i];
            req_data[8*i +: 8] = (fifoCount(i) > 0) ? fifo_mem[i][fifo_head[i] % FIFO_DEPTH] : 8'h00;
            hold_low[i] = 1'b0;
        end
        #1;
        elig = req_valid & req_mask;
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_gid = 0; m_data = 8'h00; m_start = 0; m_err = 0;
        end
        exp_ready = '0;
        win = -1;
        if (!rst && m_phase == 0 && !tx_busy) begin
            win = refPick(elig, m_ptr, prio_mode);
            if (win >= 0) exp_ready = NUM_REQ'(1) << win;
        end
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
        checkOutput("tx_start", 32'(tx_start), 32'(m_start));
        checkOutput("tx_data", 32'(tx_data), 32'(m_data));
        checkOutput("grant_id", 32'(grant_id), 32'(m_gid));
        checkOutput("sched_busy", 32'(sched_busy), 32'(m_phase != 0));
        checkOutput("err_timeout", 32'(err_timeout), 32'(m_err));
        checkOutput("start_while_busy", 32'(tx_start & tx_busy), 32'(0));
        if (tx_start) begin
            start_count++;
            last_start_cyc = cyc;
            if (!no_busy && !rst) rise_cnt = 3;
        end
        if (err_timeout && err_rise_cyc < 0) err_rise_cyc = cyc;
        if (req_ready != '0) ready_count++;
        if (req_ready[3]) ready3_count++;
        if (!rst) begin
            m_start = 0;
            case (m_phase)
                0: if (win >= 0) begin
                    m_data  = fifo_mem[win][fifo_head[win] % FIFO_DEPTH];
                    m_gid   = win;
                    m_ptr   = (win + 1) % NUM_REQ;
                    m_phase = 1;
                    m_start = 1;
                    grant_log.push_back(win);
                end
                1: begin
                    m_phase = 2;
                    m_launch_cyc = cyc;
                end
                2: if (tx_busy) m_phase = 3;
                   else if (cyc - m_launch_cyc >= BUSY_TIMEOUT - 1) begin
                       m_err   = 1;
                       m_phase = 0;
                   end
                3: if (!tx_busy) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
        // The requester sees READY and retires its byte.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && fifoCount(i) > 0) fifo_head[i]++;
        end
    endtask

    task automatic waitDrain(input int limit, input string tag);
        int n = 0;
        while ((pendingTotal() != 0 || m_phase != 0 || tx_busy || rise_cnt != 0) && n < limit) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, 32'(n < limit), 32'(1));
    endtask

    task automatic waitGrants(input int cnt, input int limit, input string tag);
        int n = 0;
        while (grant_log.size() < cnt && n < limit) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, 32'(grant_log.size() >= cnt), 32'(1));
    endtask

    task automatic doReset();
        nxt_rst = 1'b1;
        repeat (2) applyStimulus();
        nxt_rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gcyc;
        int n;
        int starts_before;
        rst = 1'b1; nxt_rst = 1'b1;
        req_valid = '0; req_data = '0;
        req_mask = '1; nxt_mask = '1;
        prio_mode = 1'b0; nxt_prio = 1'b0;
        tx_busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fifo_head[i] = 0; fifo_tail[i] = 0; hold_low[i] = 1'b0;
        end

        $display("[TB] reset");
        repeat (3) applyStimulus();
        nxt_rst = 1'b0;
        repeat (2) applyStimulus();

        $display("[TB] single full-length frame");
        frame_len = FULL_FRAME;
        grant_log.delete();
        pushByte(2, 8'hA5);
        waitGrants(1, 20, "single_grant_seen");
        gcyc = cyc;
        checkOutput("single_grant_id", 32'(logAt(0)), 32'(2));
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (sched_busy && n < FULL_FRAME + 100);
        checkOutput("single_frame_len", 32'(cyc - gcyc), 32'(FULL_FRAME + 5));
        frame_len = 20;

        $display("[TB] round-robin");
        doReset();
        grant_log.delete();
        starts_before = start_count;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < NUM_REQ; i++) pushByte(i, 8'($urandom));
        waitDrain(2000, "rr_drain");
        checkOutput("rr_grants", 32'(grant_log.size()), 32'(12));
        checkOutput("rr_starts", 32'(start_count - starts_before), 32'(12));
        for (int k = 0; k < 12; k++) checkOutput($sformatf("rr_order%0d", k), 32'(logAt(k)), 32'(k % 4));

        $display("[TB] fixed priority");
        nxt_prio = 1'b1;
        grant_log.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++) pushByte(i, 8'($urandom));
        waitDrain(2000, "fixed_drain");
        for (int k = 0; k < 8; k++) checkOutput($sformatf("fixed_order%0d", k), 32'(logAt(k)), 32'(k / 2));
        grant_log.delete();
        nxt_mask = 4'b1110;
        pushByte(0, 8'h11);
        pushByte(1, 8'h22);
        waitGrants(1, 100, "mask_grant_seen");
        checkOutput("mask_winner", 32'(logAt(0)), 32'(1));
        nxt_mask = '1;
        waitDrain(500, "mask_drain");
        checkOutput("unmask_winner", 32'(logAt(1)), 32'(0));

        $display("[TB] busy timeout");
        nxt_prio = 1'b0;
        no_busy = 1'b1;
        err_rise_cyc = -1;
        pushByte(1, 8'h5A);
        n = 0;
        while (!err_timeout && n < 60) begin
            applyStimulus();
            n++;
        end
        checkOutput("timeout_latency", 32'(err_rise_cyc - last_start_cyc), 32'(BUSY_TIMEOUT));
        starts_before = start_count;
        pushByte(3, 8'hC3);
        waitDrain(200, "timeout_drain");
        checkOutput("timeout_relaunch", 32'(start_count - starts_before), 32'(1));
        checkOutput("timeout_sticky", 32'(err_timeout), 32'(1));
        no_busy = 1'b0;

        $display("[TB] reset during frame with busy held");
        pushByte(2, 8'h77);
        n = 0;
        while (m_phase != 3 && n < 60) begin
            applyStimulus();
            n++;
        end
        checkOutput("gate_reached_wait_done", 32'(m_phase), 32'(3));
        force_busy = 1'b1;
        nxt_rst = 1'b1;
        pushByte(1, 8'h31);
        pushByte(3, 8'h33);
        repeat (2) applyStimulus();
        nxt_rst = 1'b0;
        ready_count = 0;
        starts_before = start_count;
        repeat (500) applyStimulus();
        checkOutput("gate_no_ready", 32'(ready_count), 32'(0));
        checkOutput("gate_no_start", 32'(start_count - starts_before), 32'(0));
        force_busy = 1'b0;
        grant_log.delete();
        waitDrain(500, "gate_drain");
        checkOutput("gate_order0", 32'(logAt(0)), 32'(1));
        checkOutput("gate_order1", 32'(logAt(1)), 32'(3));

        $display("[TB] withdrawal");
        grant_log.delete();
        ready3_count = 0;
        pushByte(0, 8'h40);
        waitGrants(1, 50, "withdraw_first_grant");
        pushByte(3, 8'h43);
        repeat (5) applyStimulus();
        withdrawReq(3);
        pushByte(2, 8'h42);
        waitDrain(500, "withdraw_drain");
        checkOutput("withdraw_no_ready3", 32'(ready3_count), 32'(0));
        checkOutput("withdraw_order1", 32'(logAt(1)), 32'(2));
        pushByte(1, 8'h51);
        pushByte(3, 8'h53);
        waitDrain(500, "withdraw_ptr_drain");
        checkOutput("withdraw_ptr_next", 32'(logAt(2)), 32'(3));

        $display("[TB] randomized traffic");
        for (int t = 0; t < 3000; t++) begin
            int r;
            r = $urandom_range(0, NUM_REQ - 1);
            if ($urandom_range(0, 3) == 0 && fifoCount(r) < 48) pushByte(r, 8'($urandom));
            if ($urandom_range(0, 7) == 0) nxt_mask = NUM_REQ'($urandom);
            if ($urandom_range(0, 15) == 0) nxt_prio = 1'($urandom);
            if ($urandom_range(0, 49) == 0) withdrawReq($urandom_range(0, NUM_REQ - 1));
            frame_len = $urandom_range(3, 40);
            applyStimulus();
        end
        nxt_mask = '1;
        waitDrain(10000, "final_drain");

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
